// File: rtl/bindct_pkg.sv
// Shared constants for the pipelined 8-point forward binDCT.
// Contents: stage count, default widths, and the map from the S4 result
// vector to natural DCT coefficient order.
package bindct_pkg;

  localparam int unsigned NumStages   = 4;
  localparam int unsigned NumLanes    = 8;
  localparam int unsigned DefInWidth  = 8;
  localparam int unsigned DefIntBits  = 4;
  localparam int unsigned DefFracBits = 6;
  localparam int unsigned DefOutWidth = 20;

  // The S4 result vector is ordered {d0, d1, d2, d3, d4, d5, d6, c7}.
  // out_src(k) is the index of the entry that becomes coefficient Y[k].
  function automatic int unsigned out_src(input int unsigned k);
    case (k)
      0:       return 0;  // Y0 = d0
      1:       return 7;  // Y1 = c7
      2:       return 3;  // Y2 = d3
      3:       return 6;  // Y3 = d6
      4:       return 1;  // Y4 = d1
      5:       return 5;  // Y5 = d5
      6:       return 2;  // Y6 = d2
      default: return 4;  // Y7 = d4
    endcase
  endfunction

endpackage

// File: rtl/bindct_round_sat.sv
// One output lane of the binDCT formatter: optional round-half-up, arithmetic
// right shift, then clip to a signed OUT_WIDTH range.
// Ports:
//   y_i   - signed internal coefficient (IN_W bits)
//   y_o   - formatted, clipped coefficient (OUT_WIDTH bits, two's complement)
//   sat_o - high when y_o was clipped
module bindct_round_sat #(
  parameter int unsigned IN_W      = 18,
  parameter int unsigned OUT_WIDTH = 20,
  parameter int unsigned OUT_SHIFT = 0,
  parameter int unsigned ROUND     = 1
) (
  input  logic signed [IN_W-1:0]      y_i,
  output logic        [OUT_WIDTH-1:0] y_o,
  output logic                        sat_o
);

  // One extra bit so the rounding bias can never overflow.
  localparam int unsigned ExtW = IN_W + 1;

  logic signed [ExtW-1:0] ext;
  logic signed [ExtW-1:0] bias;
  logic signed [ExtW-1:0] shr;

  assign ext = ExtW'(y_i);

  if (ROUND != 0 && OUT_SHIFT > 0) begin : g_rnd
    assign bias = ExtW'(1) <<< (OUT_SHIFT - 1);
  end else begin : g_trunc
    assign bias = '0;
  end

  assign shr = (ext + bias) >>> OUT_SHIFT;

  if (OUT_WIDTH > ExtW) begin : g_wide
    // Output range covers every representable value: sign-extend only.
    assign y_o   = {{(OUT_WIDTH - ExtW){shr[ExtW-1]}}, shr};
    assign sat_o = 1'b0;
  end else begin : g_clip
    // In range iff all bits from the output sign bit upward agree.
    logic [ExtW-OUT_WIDTH:0] hi_bits;
    logic                    ovf;
    assign hi_bits = shr[ExtW-1:OUT_WIDTH-1];
    assign ovf     = !((&hi_bits) || !(|hi_bits));
    assign sat_o   = ovf;
    assign y_o     = !ovf ? shr[OUT_WIDTH-1:0] :
                     shr[ExtW-1] ? {1'b1, {(OUT_WIDTH - 1){1'b0}}} :
                                   {1'b0, {(OUT_WIDTH - 1){1'b1}}};
  end

endmodule

// File: rtl/bindct8_pipe.sv
// Fully pipelined 8-point forward binDCT (lifting datapath) with an elastic
// valid/ready pipeline of four register stages and a round/shift/clip output.
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   in_valid / in_ready  - input handshake, x_in lanes [0..7]
//   out_valid / out_ready- output handshake, y_out lanes in natural DCT order
//   sat_out              - some lane of the current y_out was clipped
module bindct8_pipe
  import bindct_pkg::*;
#(
  parameter int unsigned IN_WIDTH    = DefInWidth,
  parameter int unsigned INT_BITS    = DefIntBits,
  parameter int unsigned FRAC_BITS   = DefFracBits,
  parameter int unsigned INTER_WIDTH = IN_WIDTH + INT_BITS + FRAC_BITS,
  parameter int unsigned OUT_WIDTH   = DefOutWidth,
  parameter int unsigned OUT_SHIFT   = 0,
  parameter int unsigned ROUND       = 1,
  parameter int unsigned LEVEL_SHIFT = 0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [NumLanes-1:0][IN_WIDTH-1:0]  x_in,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [NumLanes-1:0][OUT_WIDTH-1:0] y_out,
  output logic                               sat_out
);

  typedef logic signed [INTER_WIDTH-1:0] word_t;

  // ---------------- handshake: v_q[0] is S1, v_q[3] is the output register
  logic [NumStages-1:0] v_q;
  logic rdy1, rdy2, rdy3, rdy4;
  logic ld1, ld2, ld3, ld4;

  assign rdy4 = !v_q[3] | out_ready;
  assign rdy3 = !v_q[2] | rdy4;
  assign rdy2 = !v_q[1] | rdy3;
  assign rdy1 = !v_q[0] | rdy2;

  assign ld1 = in_valid & rdy1;
  assign ld2 = v_q[0] & rdy2;
  assign ld3 = v_q[1] & rdy3;
  assign ld4 = v_q[2] & rdy4;

  assign in_ready  = rdy1;
  assign out_valid = v_q[3];

  // A stage that can accept takes its upstream valid; one that cannot is full and stays so.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
    end else begin
      if (rdy1) v_q[0] <= in_valid;
      if (rdy2) v_q[1] <= v_q[0];
      if (rdy3) v_q[2] <= v_q[1];
      if (rdy4) v_q[3] <= v_q[2];
    end
  end

  // ---------------- datapath
  word_t s   [NumLanes];
  word_t a_d [NumLanes];
  word_t s1_q[NumLanes];
  word_t s2_d[NumLanes];
  word_t s2_q[NumLanes];
  word_t s3_d[NumLanes];
  word_t s3_q[NumLanes];
  word_t e   [NumLanes];
  word_t b0, b1;

  logic [NumLanes-1:0][OUT_WIDTH-1:0] y_d;
  logic [NumLanes-1:0]                sat_lane;

  // Entry and S1 butterflies. Level shift by 2^(IN_WIDTH-1) equals flipping the MSB.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      logic [IN_WIDTH-1:0] xs;
      xs = x_in[i];
      if (LEVEL_SHIFT != 0) xs[IN_WIDTH-1] = ~xs[IN_WIDTH-1];
      s[i] = word_t'($signed(xs));
    end
    for (int i = 0; i < 4; i++) begin
      a_d[i]   = (s[i] + s[7-i]) <<< FRAC_BITS;
      a_d[i+4] = (s[3-i] - s[4+i]) <<< FRAC_BITS;
    end
  end

  // S2: lifting on a5/a6. Stored as {a0, a1, a2, a3, a4, a7, b0, b1}.
  always_comb begin
    b0 = (s1_q[5] >>> 2) + (s1_q[5] >>> 3) + s1_q[6];
    b1 = (b0 >>> 1) + (b0 >>> 3) - s1_q[5];
    s2_d = '{s1_q[0], s1_q[1], s1_q[2], s1_q[3], s1_q[4], s1_q[7], b0, b1};
  end

  // S3 butterflies.
  always_comb begin
    s3_d[0] = s2_q[0] + s2_q[3];
    s3_d[1] = s2_q[1] + s2_q[2];
    s3_d[2] = s2_q[1] - s2_q[2];
    s3_d[3] = s2_q[0] - s2_q[3];
    s3_d[4] = s2_q[4] + s2_q[7];
    s3_d[5] = s2_q[4] - s2_q[7];
    s3_d[6] = s2_q[5] - s2_q[6];
    s3_d[7] = s2_q[5] + s2_q[6];
  end

  // S4 lifting; e = {d0, d1, d2, d3, d4, d5, d6, c7}.
  always_comb begin
    e[0] = s3_q[0] + s3_q[1];
    e[1] = (e[0] >>> 1) - s3_q[1];
    e[2] = s3_q[2] - ((s3_q[3] >>> 2) + (s3_q[3] >>> 3));
    e[3] = s3_q[3] + (e[2] >>> 2) + (e[2] >>> 3);
    e[4] = s3_q[4] - (s3_q[7] >>> 3);
    e[5] = s3_q[5] + (s3_q[6] >>> 1) + (s3_q[6] >>> 2) + (s3_q[6] >>> 3);
    e[6] = s3_q[6] - (e[5] >>> 1);
    e[7] = s3_q[7];
  end

  for (genvar k = 0; k < NumLanes; k++) begin : g_lane
    localparam int unsigned Src = out_src(k);
    bindct_round_sat #(
      .IN_W      (INTER_WIDTH),
      .OUT_WIDTH (OUT_WIDTH),
      .OUT_SHIFT (OUT_SHIFT),
      .ROUND     (ROUND)
    ) u_round_sat (
      .y_i   (e[Src]),
      .y_o   (y_d[k]),
      .sat_o (sat_lane[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= '{default: '0};
      s2_q    <= '{default: '0};
      s3_q    <= '{default: '0};
      y_out   <= '0;
      sat_out <= 1'b0;
    end else begin
      if (ld1) s1_q <= a_d;
      if (ld2) s2_q <= s2_d;
      if (ld3) s3_q <= s3_d;
      if (ld4) begin
        y_out   <= y_d;
        sat_out <= |sat_lane;
      end
    end
  end

endmodule

// File: doc/bindct8_pipe.md
Name: bindct8_pipe

Overview:
Parametrised, fully pipelined successor to the fixed 8-point forward binDCT. It accepts one 8-sample row or column per cycle over a valid/ready handshake, with full backpressure, and runs the same lifting datapath as four elastic register stages. An optional level shift, rounding and saturating output formatter sit at the output. It sits between the pixel/block buffer and the quantiser in the JPEG-style pipeline.

Parameters:
IN_WIDTH, 8, input sample width.
INT_BITS, 4, guard bits against growth.
FRAC_BITS, 6, fractional bits added at stage 1.
INTER_WIDTH, IN_WIDTH+INT_BITS+FRAC_BITS, internal signed width.
OUT_WIDTH, 20, output coefficient width (signed).
OUT_SHIFT, 0, arithmetic right shift applied at output (0..FRAC_BITS).
ROUND, 1, 1 = round half up before OUT_SHIFT; 0 = truncate (floor).
LEVEL_SHIFT, 0, 1 = inputs unsigned, 2^(IN_WIDTH-1) subtracted on entry; 0 = inputs signed.

Ports:
clk  in  1  clock.
rst  in  1  reset.
in_valid  in  1  x_in holds a valid vector.
in_ready  out  1  block can accept this cycle.
x_in  in  IN_WIDTH x 8  input samples [0..7].
out_valid  out  1  y_out is valid.
out_ready  in  1  downstream accepts.
y_out  out  OUT_WIDTH x 8  coefficients, natural DCT order [0..7].
sat_out  out  1  at least one lane of the current y_out was clipped.

Behaviour:
- One clock, clk; reset rst is synchronous and active-high. On reset: all stage valid bits 0, out_valid=0, sat_out=0, y_out=0, data regs 0. in_ready is 1 in the cycle after reset. Reset mid-stream discards all in-flight vectors; nothing is emitted afterwards.
- Elastic pipeline, stages S1..S4, each with a valid bit. Stage k loads when its upstream is valid and (stage k is empty or stage k advances this cycle). in_ready = !v1 | ready1. S4 is the output register: out_valid=v4; it drains on out_valid & out_ready. Pass-through ready is combinational; there are no bubbles under continuous flow.
- Latency: 4 cycles from accept (in_valid & in_ready) to out_valid. Throughput is 1 vector/cycle. Capacity is 4 vectors. Order is preserved; no vector is dropped or duplicated. y_out and sat_out stay stable while out_valid & !out_ready.
- Entry: s_i = x_i signed (or x_i - 2^(IN_WIDTH-1) if LEVEL_SHIFT), sign-extended to INTER_WIDTH. All >>> are arithmetic; all sums wrap at INTER_WIDTH (the guard bits are sized so that no wrap occurs for legal inputs).
- S1: a0..a3 = (s0+s7, s1+s6, s2+s5, s3+s4) << FRAC_BITS; a4..a7 = (s3-s4, s2-s5, s1-s6, s0-s7) << FRAC_BITS.
- S2: b0 = (a5>>>2)+(a5>>>3)+a6; b1 = (b0>>>1)+(b0>>>3)-a5. a0..a4 and a7 are carried forward.
- S3: c0=a0+a3, c1=a1+a2, c2=a1-a2, c3=a0-a3, c4=a4+b1, c5=a4-b1, c6=a7-b0, c7=a7+b0.
- S4 (combinational into the output register):
  - d0=c0+c1; d1=(d0>>>1)-c1
  - d2=c2-((c3>>>2)+(c3>>>3)); d3=c3+(d2>>>2)+(d2>>>3)
  - d4=c4-(c7>>>3); d5=c5+(c6>>>1)+(c6>>>2)+(c6>>>3); d6=c6-(d5>>>1)
- Coefficient mapping: Y0=d0, Y1=c7, Y2=d3, Y3=d6, Y4=d1, Y5=d5, Y6=d2, Y7=d4.
- Format each lane: r = (Y + (ROUND && OUT_SHIFT>0 ? 1<<(OUT_SHIFT-1) : 0)) >>> OUT_SHIFT, computed at INTER_WIDTH+1 bits. y = clip(r) to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]. sat_out = OR of the per-lane clip flags, registered with y_out.
- Simultaneous accept and drain while full: the load proceeds and occupancy is unchanged.

Decomposition:
- Package bindct_pkg: stage count constant (4), default width constants, and the output-mapping index table.
- One sub-module, bindct_round_sat (one lane: round, shift, clip, sat flag), instantiated 8 times in S4.
- Stage valid/ready control stays in the top module.

Test Plan:
- Reset, then x=0 all lanes, signed -> after 4 cycles out_valid=1, y=all 0, sat_out=0.
- Signed DC: x=10 all lanes, OUT_SHIFT=0 -> y=[5120,0,0,0,0,0,0,0]. LEVEL_SHIFT=1 with x=128 all lanes -> all 0.
- Impulse x0=1, others 0, OUT_SHIFT=0 -> y=[64,64,55,36,32,56,-24,-8]. OUT_SHIFT=6, ROUND=1 -> [1,1,1,1,1,1,0,0]. ROUND=0 -> [1,1,0,0,0,0,-1,-1].
- Saturation: OUT_WIDTH=12, x=127 all lanes -> y0=2047, others 0, sat_out=1. x=-128 all lanes -> y0=-2048, sat_out=1.
- Backpressure: out_ready=0, offer 6 distinct vectors -> exactly 4 accepted, then in_ready=0 and y_out held stable. Raise out_ready -> all 6 emitted in order, one per cycle, with no loss or duplication. Also check random out_ready toggling against a golden model.
- Reset mid-stream with 3 vectors in flight -> out_valid=0 the next cycle, no stale output later, and in_ready=1.
